// File: rtl/camera_controller.sv
// Capture sequencer for a 2x2 pixel-array camera.
// Adjustable exposure, then a two-row readout with ADC strobes.
module camera_controller #(
    parameter int unsigned EXP_MIN   = 2,
    parameter int unsigned EXP_MAX   = 30,
    parameter int unsigned EXP_RESET = 2,
    parameter int unsigned EXP_W     = 5
) (
    input  logic init,
    input  logic exp_increase,
    input  logic exp_decrease,
    input  logic clk,
    input  logic rst,
    output logic NRE_1,
    output logic NRE_2,
    output logic ADC,
    output logic expose,
    output logic erase
);

    localparam logic [EXP_W-1:0] MIN_C = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] MAX_C = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] RST_C = EXP_W'(EXP_RESET);
    localparam logic [EXP_W-1:0] ONE_C = EXP_W'(1);
    localparam logic [EXP_W-1:0] LAST_C = EXP_W'(5);

    typedef enum logic [1:0] {
        IDLE,
        EXPOSURE,
        READOUT
    } state_e;

    state_e           state_q, state_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;

    // State, exposure setting and phase counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            exp_q   <= RST_C;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        NRE_1   = 1'b1;
        NRE_2   = 1'b1;
        ADC     = 1'b0;
        expose  = 1'b0;
        erase   = 1'b0;
        unique case (state_q)
            IDLE: begin
                erase = 1'b1;
                if (exp_increase && !exp_decrease && exp_q < MAX_C) begin
                    exp_d = exp_q + ONE_C;
                end else if (exp_decrease && !exp_increase && exp_q > MIN_C) begin
                    exp_d = exp_q - ONE_C;
                end
                // Counter takes the setting as it stood before this edge
                if (init) begin
                    state_d = EXPOSURE;
                    cnt_d   = exp_q;
                end
            end
            EXPOSURE: begin
                expose = 1'b1;
                if (cnt_q <= ONE_C) begin
                    state_d = READOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            READOUT: begin
                // Steps 0-2 read row 1, steps 3-5 read row 2
                if (cnt_q < EXP_W'(3)) begin
                    NRE_1 = 1'b0;
                end else begin
                    NRE_2 = 1'b0;
                end
                ADC = (cnt_q == ONE_C) || (cnt_q == EXP_W'(4));
                if (cnt_q >= LAST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                erase   = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_camera_controller.sv
// Directed-vector bench for camera_controller.
// Exposure setting is observed through the expose pulse width.
module tb_camera_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b0;
    logic exp_increase = 1'b0;
    logic exp_decrease = 1'b0;
    logic NRE_1, NRE_2, ADC, expose, erase;
    logic [4:0] obs;

    int vectors = 0;
    int miscompares = 0;

    camera_controller dut (
        .init(init),
        .exp_increase(exp_increase),
        .exp_decrease(exp_decrease),
        .clk(clk),
        .rst(rst),
        .NRE_1(NRE_1),
        .NRE_2(NRE_2),
        .ADC(ADC),
        .expose(expose),
        .erase(erase)
    );

    always #5 clk = ~clk;

    assign obs = {NRE_1, NRE_2, ADC, expose, erase};

    // Reset pulse; returns on a falling edge with rst low
    task automatic do_reset();
        init = 0;
        exp_increase = 0;
        exp_decrease = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    // Pulse init from IDLE, measure expose width, then record
    // whether the readout strobes follow the expected order.
    task automatic capture(output int ew, output logic ro_ok);
        logic [4:0] tab [0:6];
        tab[0] = 5'b01000;
        tab[1] = 5'b01100;
        tab[2] = 5'b01000;
        tab[3] = 5'b10000;
        tab[4] = 5'b10100;
        tab[5] = 5'b10000;
        tab[6] = 5'b11001;
        ew = 0;
        ro_ok = 1'b1;
        init = 1;
        @(negedge clk);
        init = 0;
        while (expose === 1'b1 && ew < 40) begin
            ew++;
            @(negedge clk);
        end
        for (int i = 0; i < 7; i++) begin
            if (obs !== tab[i]) ro_ok = 1'b0;
            if (i < 6) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        #2;
        vectors++;
        if (obs !== 5'b11001) begin
            miscompares++;
            $display("FAIL reset_async obs=%b exp=%b", obs, 5'b11001);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        vectors++;
        if (obs !== 5'b11001) begin
            miscompares++;
            $display("FAIL reset_idle obs=%b exp=%b", obs, 5'b11001);
        end
    endtask

    task automatic test_basic();
        int w;
        logic ok;
        do_reset();
        capture(w, ok);
        vectors++;
        if (w !== 2) begin
            miscompares++;
            $display("FAIL basic_width got=%0d exp=2", w);
        end
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_readout got=%b exp=1", ok);
        end
    endtask

    task automatic test_sat_max();
        int w;
        logic ok;
        do_reset();
        exp_increase = 1;
        repeat (33) @(negedge clk);
        exp_increase = 0;
        capture(w, ok);
        vectors++;
        if (w !== 30) begin
            miscompares++;
            $display("FAIL sat_max_width got=%0d exp=30", w);
        end
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_max_readout got=%b exp=1", ok);
        end
    endtask

    task automatic test_both_then_min();
        int w;
        logic ok;
        exp_increase = 1;
        exp_decrease = 1;
        repeat (3) @(negedge clk);
        exp_increase = 0;
        exp_decrease = 0;
        capture(w, ok);
        vectors++;
        if (w !== 30) begin
            miscompares++;
            $display("FAIL both_high_width got=%0d exp=30", w);
        end
        exp_decrease = 1;
        repeat (40) @(negedge clk);
        exp_decrease = 0;
        capture(w, ok);
        vectors++;
        if (w !== 2) begin
            miscompares++;
            $display("FAIL sat_min_width got=%0d exp=2", w);
        end
    endtask

    task automatic test_ignore();
        int w;
        logic ok;
        do_reset();
        exp_increase = 1;
        repeat (5) @(negedge clk);
        exp_increase = 0;
        fork
            capture(w, ok);
            begin
                repeat (12) begin
                    @(negedge clk);
                    exp_increase = ~exp_increase;
                end
            end
        join
        exp_increase = 0;
        vectors++;
        if (w !== 7) begin
            miscompares++;
            $display("FAIL ignore_width got=%0d exp=7", w);
        end
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_readout got=%b exp=1", ok);
        end
        capture(w, ok);
        vectors++;
        if (w !== 7) begin
            miscompares++;
            $display("FAIL ignore_next_width got=%0d exp=7", w);
        end
    endtask

    task automatic test_same_edge();
        int w;
        logic ok;
        exp_decrease = 1;
        capture(w, ok);
        exp_decrease = 0;
        vectors++;
        if (w !== 7) begin
            miscompares++;
            $display("FAIL same_edge_width got=%0d exp=7", w);
        end
        capture(w, ok);
        vectors++;
        if (w !== 6) begin
            miscompares++;
            $display("FAIL same_edge_next got=%0d exp=6", w);
        end
    endtask

    task automatic test_back_to_back();
        int n_erase = 0;
        int n_expose = 0;
        int n_bad = 0;
        logic [4:0] prev;
        do_reset();
        prev = obs;
        init = 1;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (obs[1]) n_expose++;
            if (obs[0]) n_erase++;
            if (!obs[4] && !obs[3]) n_bad++;
            if (!prev[3] && obs[1]) n_bad++;
            prev = obs;
        end
        init = 0;
        vectors++;
        if (n_expose !== 6) begin
            miscompares++;
            $display("FAIL b2b_expose got=%0d exp=6", n_expose);
        end
        vectors++;
        if (n_erase !== 3) begin
            miscompares++;
            $display("FAIL b2b_erase got=%0d exp=3", n_erase);
        end
        vectors++;
        if (n_bad !== 0) begin
            miscompares++;
            $display("FAIL b2b_overlap got=%0d exp=0", n_bad);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int w;
        logic ok;
        do_reset();
        exp_increase = 1;
        repeat (8) @(negedge clk);
        exp_increase = 0;
        init = 1;
        @(negedge clk);
        init = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== 5'b11010) begin
            miscompares++;
            $display("FAIL mid_exp_state obs=%b exp=%b", obs, 5'b11010);
        end
        #2 rst = 1;
        #1;
        vectors++;
        if (obs !== 5'b11001) begin
            miscompares++;
            $display("FAIL rst_mid_exp obs=%b exp=%b", obs, 5'b11001);
        end
        @(negedge clk);
        rst = 0;
        exp_increase = 1;
        repeat (3) @(negedge clk);
        exp_increase = 0;
        init = 1;
        @(negedge clk);
        init = 0;
        repeat (6) @(negedge clk);
        vectors++;
        if (obs !== 5'b01100) begin
            miscompares++;
            $display("FAIL mid_ro_state obs=%b exp=%b", obs, 5'b01100);
        end
        #2 rst = 1;
        #1;
        vectors++;
        if (obs !== 5'b11001) begin
            miscompares++;
            $display("FAIL rst_mid_ro obs=%b exp=%b", obs, 5'b11001);
        end
        @(negedge clk);
        rst = 0;
        capture(w, ok);
        vectors++;
        if (w !== 2) begin
            miscompares++;
            $display("FAIL rst_exp_restore got=%0d exp=2", w);
        end
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_after_readout got=%b exp=1", ok);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_max();
        test_both_then_min();
        test_ignore();
        test_same_edge();
        test_back_to_back();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
